// File: rtl/icache_pkg.sv
// icache_pkg: derived geometry helpers and refill FSM states for param_instruction_cache
package icache_pkg;

    typedef enum logic [2:0] {IDLE, LOOKUP, REQ, FILL, RESP} state_t;

    function automatic int off_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int set_w(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_w(input int addr_width, input int words_per_line, input int num_sets);
        return addr_width - off_w(words_per_line) - set_w(num_sets);
    endfunction

    function automatic int beats(input int words_per_line, input int word_width, input int mem_data_width);
        return words_per_line * word_width / mem_data_width;
    endfunction

    function automatic int beat_w(input int words_per_line, input int word_width, input int mem_data_width);
        return beats(words_per_line, word_width, mem_data_width) > 1 ?
               $clog2(beats(words_per_line, word_width, mem_data_width)) : 1;
    endfunction

endpackage

// File: rtl/icache_nru_victim_sel.sv
// icache_nru_victim_sel: NRU victim choice and use-bit update for one cache set
module icache_nru_victim_sel #(
    parameter int NUM_WAYS = 4
) (
    input  logic [NUM_WAYS-1:0] valid,
    input  logic [NUM_WAYS-1:0] use_bits,
    input  logic [NUM_WAYS-1:0] hit,
    output logic [NUM_WAYS-1:0] victim,
    output logic [NUM_WAYS-1:0] use_next
);

    logic found;

    // Lowest invalid way wins, then lowest unused way; way 0 is a safe fallback
    always_comb begin
        victim = '0;
        found  = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++)
            if (!found && !valid[w]) begin
                victim[w] = 1'b1;
                found     = 1'b1;
            end
        for (int w = 0; w < NUM_WAYS; w++)
            if (!found && !use_bits[w]) begin
                victim[w] = 1'b1;
                found     = 1'b1;
            end
        if (!found)
            victim[0] = 1'b1;
        use_next = &(use_bits | hit) ? hit : (use_bits | hit);
    end

endmodule

// File: rtl/param_instruction_cache.sv
// param_instruction_cache: blocking N-way set-associative I-cache with NRU refill; ICACHE_PERF_CNT_EN adds hit/miss counters
module param_instruction_cache
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int WORD_WIDTH     = 20,
    parameter int NUM_WAYS       = 4,
    parameter int NUM_SETS       = 16,
    parameter int WORDS_PER_LINE = 8,
    parameter int MEM_DATA_WIDTH = 40
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    input  logic                      i_valid,
    input  logic                      i_halt,
    input  logic                      i_flush,
    input  logic [MEM_DATA_WIDTH-1:0] i_mem_data,
    input  logic                      i_mem_data_valid,
    input  logic                      i_mem_req_ready,
    output logic [WORD_WIDTH-1:0]     o_data,
    output logic                      o_valid,
    output logic                      o_ready,
    output logic [ADDR_WIDTH-1:0]     o_mem_addr,
    output logic                      o_mem_req_valid,
    output logic                      o_mem_if_ready
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]               o_hit_count,
    output logic [31:0]               o_miss_count
`endif
);

    localparam int OFF_W  = off_w(WORDS_PER_LINE);
    localparam int SET_W  = set_w(NUM_SETS);
    localparam int TAG_W  = tag_w(ADDR_WIDTH, WORDS_PER_LINE, NUM_SETS);
    localparam int BEATS  = beats(WORDS_PER_LINE, WORD_WIDTH, MEM_DATA_WIDTH);
    localparam int BEAT_W = beat_w(WORDS_PER_LINE, WORD_WIDTH, MEM_DATA_WIDTH);
    localparam int LINE_W = WORDS_PER_LINE * WORD_WIDTH;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [TAG_W-1:0]      tag_q  [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0]     data_q [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]   use_q   [NUM_SETS];
    logic [LINE_W-1:0]     buf_q, line_d;
    logic [BEAT_W-1:0]     cnt_q;
    logic                  pend_q;
    logic [SET_W-1:0]      set;
    logic [TAG_W-1:0]      tag;
    logic [OFF_W-1:0]      off;
    logic [NUM_WAYS-1:0]   hit_vec, victim, use_next, acc;
    logic [WORD_WIDTH-1:0] hit_word;
    logic                  hit, accept, beat, last_beat, flush_now;

    assign set       = addr_q[OFF_W +: SET_W];
    assign tag       = addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign off       = addr_q[OFF_W-1:0];
    assign hit       = state_q == LOOKUP && |hit_vec;
    assign o_ready   = arst_n && !i_halt && !i_flush && (state_q == IDLE || hit);
    assign accept    = i_valid && o_ready;
    assign beat      = state_q == FILL && i_mem_data_valid && !i_halt;
    assign last_beat = beat && cnt_q == BEAT_W'(BEATS - 1);
    assign flush_now = !i_halt && ((i_flush && (state_q == IDLE || state_q == LOOKUP)) ||
                                   (state_q == RESP && (pend_q || i_flush)));
    assign acc       = state_q == FILL ? victim : hit_vec;

    assign o_valid         = hit || state_q == RESP;
    assign o_data          = hit ? hit_word : state_q == RESP ? buf_q[off*WORD_WIDTH +: WORD_WIDTH] : '0;
    assign o_mem_req_valid = state_q == REQ;
    assign o_mem_addr      = state_q == REQ ? {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign o_mem_if_ready  = state_q == FILL && !i_halt;

    icache_nru_victim_sel #(.NUM_WAYS(NUM_WAYS)) u_nru (
        .valid    (valid_q[set]),
        .use_bits (use_q[set]),
        .hit      (acc),
        .victim   (victim),
        .use_next (use_next)
    );

    // Parallel tag compare across the ways of the addressed set
    always_comb begin
        hit_vec  = '0;
        hit_word = '0;
        for (int w = 0; w < NUM_WAYS; w++)
            if (valid_q[set][w] && tag_q[set][w] == tag) begin
                hit_vec[w] = 1'b1;
                hit_word   = data_q[set][w][off*WORD_WIDTH +: WORD_WIDTH];
            end
    end

    // Line buffer with the incoming beat merged at the current beat slot
    always_comb begin
        line_d = buf_q;
        line_d[cnt_q*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = i_mem_data;
    end

    // Next-state logic; halt freezes the FSM
    always_comb begin
        state_d = state_q;
        if (!i_halt)
            case (state_q)
                IDLE:    state_d = accept ? LOOKUP : IDLE;
                LOOKUP:  state_d = hit ? (accept ? LOOKUP : IDLE) : REQ;
                REQ:     state_d = i_mem_req_ready ? FILL : REQ;
                FILL:    state_d = last_beat ? RESP : FILL;
                RESP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
    end

    // Control state: FSM, beat counter, sticky flush, valid and use bits
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                use_q[s]   <= '0;
            end
        end else if (!i_halt) begin
            state_q <= state_d;
            if (beat)
                cnt_q <= last_beat ? '0 : cnt_q + BEAT_W'(1);
            pend_q <= state_q == RESP ? 1'b0 : (pend_q || (i_flush && (state_q == REQ || state_q == FILL)));
            if (hit || last_beat)
                use_q[set] <= use_next;
            if (last_beat)
                valid_q[set] <= valid_q[set] | victim;
            if (flush_now)
                for (int s = 0; s < NUM_SETS; s++) begin
                    valid_q[s] <= '0;
                    use_q[s]   <= '0;
                end
        end
    end

    // Unreset datapath: request address, line buffer, tag and data arrays
    always_ff @(posedge clk) begin
        if (!i_halt) begin
            if (accept)
                addr_q <= i_addr;
            if (beat)
                buf_q <= line_d;
            if (last_beat)
                for (int w = 0; w < NUM_WAYS; w++)
                    if (victim[w]) begin
                        tag_q[set][w]  <= tag;
                        data_q[set][w] <= line_d;
                    end
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    // Saturating lookup outcome counters, untouched by flush
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            o_hit_count  <= '0;
            o_miss_count <= '0;
        end else if (!i_halt && state_q == LOOKUP) begin
            if (hit && o_hit_count != '1)
                o_hit_count <= o_hit_count + 32'd1;
            if (!hit && o_miss_count != '1)
                o_miss_count <= o_miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_param_instruction_cache.sv
// tb_param_instruction_cache: directed bench with a transaction-level cache model and memory responder
module tb_param_instruction_cache;

    typedef struct {
        logic [15:0] addr;
        bit          hit;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [15:0] i_addr = '0;
    logic        i_valid = 1'b0;
    logic        i_halt = 1'b0;
    logic        i_flush = 1'b0;
    logic [39:0] i_mem_data = '0;
    logic        i_mem_data_valid = 1'b0;
    logic        i_mem_req_ready = 1'b0;
    logic [19:0] o_data;
    logic        o_valid, o_ready, o_mem_req_valid, o_mem_if_ready;
    logic [15:0] o_mem_addr;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] o_hit_count, o_miss_count;
`endif

    int total = 0, bad = 0, cyc = 0;
    int n_req = 0, run = 0, max_run = 0;
    int n_hit_m = 0, n_miss_m = 0;
    int req_delay = 0, halt_beat = -1, flush_beat = -1;
    bit busy = 0;
    logic [19:0] last_data = '0;
    logic [15:0] last_mem_addr = '0;
    exp_t q[$];
    logic [15:0] mq[$];
    exp_t e;

    bit       m_v [16][4];
    bit       m_u [16][4];
    int       m_tag [16][4];

    param_instruction_cache dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .i_addr           (i_addr),
        .i_valid          (i_valid),
        .i_halt           (i_halt),
        .i_flush          (i_flush),
        .i_mem_data       (i_mem_data),
        .i_mem_data_valid (i_mem_data_valid),
        .i_mem_req_ready  (i_mem_req_ready),
        .o_data           (o_data),
        .o_valid          (o_valid),
        .o_ready          (o_ready),
        .o_mem_addr       (o_mem_addr),
        .o_mem_req_valid  (o_mem_req_valid),
        .o_mem_if_ready   (o_mem_if_ready)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .o_hit_count      (o_hit_count),
        .o_miss_count     (o_miss_count)
`endif
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [19:0] word_of(input logic [15:0] a);
        return 20'(32'hA0000 + 32'(a) - 32'h120);
    endfunction

    function automatic logic [39:0] beat_of(input logic [15:0] line, input int k);
        logic [39:0] b;
        for (int j = 0; j < 2; j++)
            b[j*20 +: 20] = word_of(line + 16'(2*k + j));
        return b;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 4; w++) begin
                m_v[s][w] = 0;
                m_u[s][w] = 0;
            end
    endfunction

    function automatic void model_touch(input int s, input int w);
        int n = 0;
        m_u[s][w] = 1;
        for (int i = 0; i < 4; i++) n += int'(m_u[s][i]);
        if (n == 4)
            for (int i = 0; i < 4; i++) m_u[s][i] = (i == w);
    endfunction

    function automatic bit model_access(input logic [15:0] a);
        int s = int'(a[6:3]);
        int t = int'(a[15:7]);
        int v = -1;
        for (int w = 0; w < 4; w++)
            if (m_v[s][w] && m_tag[s][w] == t) begin
                model_touch(s, w);
                return 1;
            end
        for (int w = 3; w >= 0; w--) if (!m_u[s][w]) v = w;
        for (int w = 3; w >= 0; w--) if (!m_v[s][w]) v = w;
        if (v < 0) v = 0;
        m_v[s][v] = 1;
        m_tag[s][v] = t;
        model_touch(s, v);
        return 0;
    endfunction

    // Response checker: every o_valid cycle is matched against the oldest accepted request
    always @(negedge clk) begin
        if (arst_n && !i_halt) begin
            if (o_valid) begin
                run++;
                if (run > max_run) max_run = run;
                last_data = o_data;
                if (q.size() == 0)
                    chk("spurious_valid", 1, 0);
                else begin
                    e = q.pop_front();
                    chk($sformatf("data@%h", e.addr), o_data, word_of(e.addr));
                    chk($sformatf("latency@%h", e.addr), e.hit ? (cyc == e.cyc + 1) : (cyc > e.cyc + 1), 1);
                end
            end else
                run = 0;
        end
    end

    // Memory responder: answers refill requests, optionally halting or flushing mid-line
    initial begin
        logic [15:0] line;
        bit ok;
        forever begin
            @(negedge clk);
            if (arst_n && o_mem_req_valid) begin
                busy = 1;
                n_req++;
                last_mem_addr = o_mem_addr;
                line = o_mem_addr;
                if (mq.size() == 0)
                    chk("unexpected_req", 1, 0);
                else begin
                    line = mq.pop_front();
                    chk("mem_addr", o_mem_addr, line);
                end
                repeat (req_delay) @(posedge clk);
                #1 i_mem_req_ready = 1;
                @(posedge clk);
                #1 i_mem_req_ready = 0;
                for (int k = 0; k < 4; k++) begin
                    i_mem_data = beat_of(line, k);
                    i_mem_data_valid = 1;
                    if (k == halt_beat) begin
                        i_halt = 1;
                        repeat (3) begin
                            @(negedge clk);
                            chk("halt_if_ready", o_mem_if_ready, 0);
                            @(posedge clk);
                            #1;
                        end
                        i_halt = 0;
                    end
                    if (k == flush_beat) begin
                        i_flush = 1;
                        model_clear();
                    end
                    ok = 0;
                    for (int n = 0; n < 50 && !ok; n++) begin
                        @(negedge clk);
                        ok = o_mem_if_ready;
                        @(posedge clk);
                        #1;
                    end
                    i_flush = 0;
                    if (!ok) chk("beat_timeout", 0, 1);
                end
                i_mem_data_valid = 0;
                busy = 0;
            end
        end
    end

    task automatic do_reset();
        arst_n = 0;
        i_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_ready", o_ready, 0);
        chk("rst_req", o_mem_req_valid, 0);
        chk("rst_if_ready", o_mem_if_ready, 0);
        chk("rst_mem_addr", o_mem_addr, 0);
        q.delete();
        mq.delete();
        model_clear();
        n_hit_m = 0;
        n_miss_m = 0;
        @(posedge clk);
        #1 arst_n = 1;
        @(negedge clk);
        chk("idle_ready", o_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] a);
        bit h;
        i_addr = a;
        i_valid = 1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (o_ready) begin
                h = model_access(a);
                q.push_back('{a, h, cyc});
                if (!h) mq.push_back({a[15:3], 3'b000});
                if (h) n_hit_m++; else n_miss_m++;
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            if (q.size() == 0 && mq.size() == 0 && !busy) return;
            @(posedge clk);
            #1;
        end
        chk("drain_timeout", 0, 1);
    endtask

    task automatic read_lit(input logic [15:0] a, input int exp_miss, input logic [19:0] exp_word);
        int r0 = n_req;
        issue(a);
        i_valid = 0;
        drain();
        chk($sformatf("misses@%h", a), n_req - r0, exp_miss);
        chk($sformatf("word@%h", a), last_data, exp_word);
    endtask

    initial begin
        do_reset();

        req_delay = 2;
        read_lit(16'h0120, 1, 20'hA0000);
        chk("cold_mem_addr", last_mem_addr, 16'h0120);
        req_delay = 0;
        read_lit(16'h0123, 0, 20'hA0003);

        max_run = 0;
        for (int i = 0; i < 8; i++) issue(16'h0120 + 16'(i));
        i_valid = 0;
        drain();
        chk("stream_run", max_run, 8);
        chk("stream_last", last_data, 20'hA0007);

        do_reset();
        read_lit(16'h0020, 1, 20'h9FF00);
        read_lit(16'h00A0, 1, 20'h9FF80);
        read_lit(16'h0120, 1, 20'hA0000);
        read_lit(16'h01A0, 1, 20'hA0080);
        read_lit(16'h0020, 0, 20'h9FF00);
        read_lit(16'h0220, 1, 20'hA0100);
        read_lit(16'h00A0, 1, 20'h9FF80);
        read_lit(16'h0020, 0, 20'h9FF00);

        flush_beat = 1;
        read_lit(16'h0300, 1, 20'hA01E0);
        flush_beat = -1;
        read_lit(16'h0300, 1, 20'hA01E0);
        read_lit(16'h0020, 1, 20'h9FF00);

        i_flush = 1;
        @(negedge clk);
        chk("flush_ready", o_ready, 0);
        model_clear();
        @(posedge clk);
        #1 i_flush = 0;
        read_lit(16'h0020, 1, 20'h9FF00);

        halt_beat = 2;
        read_lit(16'h0455, 1, 20'hA0335);
        halt_beat = -1;
        read_lit(16'h0452, 0, 20'hA0332);

        do_reset();
`ifdef ICACHE_PERF_CNT_EN
        chk("perf_hit_rst", o_hit_count, 0);
        chk("perf_miss_rst", o_miss_count, 0);
`endif
        for (int i = 0; i < 8; i++) issue(16'h0120 + 16'(i));
        i_valid = 0;
        drain();
        chk("model_hits", n_hit_m, 7);
        chk("model_misses", n_miss_m, 1);
`ifdef ICACHE_PERF_CNT_EN
        chk("perf_hit", o_hit_count, 32'(n_hit_m));
        chk("perf_miss", o_miss_count, 32'(n_miss_m));
        chk("perf_hit_lit", o_hit_count, 7);
        chk("perf_miss_lit", o_miss_count, 1);
`endif
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
